find_sweep_ctrl: RTL and testbench

Sequencer for one `find` search engine. It runs a sweep over a host-supplied offset range and, for each offset, resets the engine, waits for its done flag and captures the engine's result. Across the whole sweep it keeps the global minimum-energy sequence and the offset that produced it. It sits between the host register file (start/abort/range in, best result/status out) and the `find` instance (offset and reset out, seq/e/done in).

---
 rtl/find_sweep_ctrl_pkg.sv | 34 +++
 rtl/find_sweep_ctrl_best_tracker.sv | 52 +++++
 rtl/find_sweep_ctrl.sv | 175 +++++++++++++++++
 tb/tb_find_sweep_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/find_sweep_ctrl_pkg.sv
// Shared definitions for the find sweep sequencer: states, status bits, default widths.
package find_sweep_ctrl_pkg;

  // Default widths shared with the find engine
  localparam int unsigned SEQ_WIDTH_DEF  = 8;
  localparam int unsigned E_WIDTH_DEF    = 20;
  localparam int unsigned OFF_WIDTH_DEF  = 7;
  localparam int unsigned RST_CYCLES_DEF = 4;
  localparam int unsigned TO_WIDTH_DEF   = 24;

  // Sequencer state encoding
  localparam int unsigned STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    ST_IDLE = 3'd0,
    ST_ERST = 3'd1,
    ST_RUN  = 3'd2,
    ST_CAPT = 3'd3,
    ST_NEXT = 3'd4,
    ST_FIN  = 3'd5
  } state_e;

  // Status word layout: {err_range, aborted, timeout_seen}
  localparam int unsigned STATUS_WIDTH = 3;
  localparam int unsigned STAT_ERR     = 2;
  localparam int unsigned STAT_ABT     = 1;
  localparam int unsigned STAT_TO      = 0;

  // Engine is out of reset while it runs and while its result is consumed
  function automatic logic eng_released(input state_e s);
    return (s == ST_RUN) || (s == ST_CAPT) || (s == ST_NEXT);
  endfunction

endpackage

// File: rtl/find_sweep_ctrl_best_tracker.sv
// Keeps the minimum-energy result seen so far; strict compare so ties keep the earlier offset.
module find_sweep_ctrl_best_tracker
  import find_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SEQ_WIDTH = SEQ_WIDTH_DEF,
  parameter int unsigned E_WIDTH   = E_WIDTH_DEF,
  parameter int unsigned OFF_WIDTH = OFF_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 cap,
  input  logic [SEQ_WIDTH-1:0] seq,
  input  logic [E_WIDTH-1:0]   e,
  input  logic [OFF_WIDTH-1:0] off,
  output logic                 best_valid,
  output logic [SEQ_WIDTH-1:0] best_seq,
  output logic [E_WIDTH-1:0]   best_e,
  output logic [OFF_WIDTH-1:0] best_off
);

  logic load_c;

  // Load when capturing the first result or a strictly lower energy
  always_comb begin
    load_c = 1'b0;
    if (cap && (!best_valid || (e < best_e))) begin
      load_c = 1'b1;
    end
  end

  // Best-result registers; clear restores the empty (all-ones energy) state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_valid <= 1'b0;
      best_seq   <= '0;
      best_e     <= '1;
      best_off   <= '0;
    end else if (clr) begin
      best_valid <= 1'b0;
      best_seq   <= '0;
      best_e     <= '1;
      best_off   <= '0;
    end else if (load_c) begin
      best_valid <= 1'b1;
      best_seq   <= seq;
      best_e     <= e;
      best_off   <= off;
    end
  end

endmodule

// File: rtl/find_sweep_ctrl.sv
// Sweeps a find engine over an offset range, tracking the global minimum-energy result.
module find_sweep_ctrl
  import find_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SEQ_WIDTH  = SEQ_WIDTH_DEF,
  parameter int unsigned E_WIDTH    = E_WIDTH_DEF,
  parameter int unsigned OFF_WIDTH  = OFF_WIDTH_DEF,
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
  parameter int unsigned TO_WIDTH   = TO_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [OFF_WIDTH-1:0]    i_off_first,
  input  logic [OFF_WIDTH-1:0]    i_off_last,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [STATUS_WIDTH-1:0] o_status,
  output logic                    o_best_valid,
  output logic [SEQ_WIDTH-1:0]    o_best_seq,
  output logic [E_WIDTH-1:0]      o_best_e,
  output logic [OFF_WIDTH-1:0]    o_best_off,
  output logic                    o_eng_rst,
  output logic [OFF_WIDTH-1:0]    o_eng_offset,
  input  logic [SEQ_WIDTH-1:0]    i_eng_seq,
  input  logic [E_WIDTH-1:0]      i_eng_e,
  input  logic                    i_eng_done
);

  localparam int unsigned RC_WIDTH = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_WIDTH-1:0] RC_LAST = RC_WIDTH'(RST_CYCLES - 1);
  // Leaving RUN when the counter is one below all-ones bounds RUN to 2^TO_WIDTH-1 cycles
  localparam logic [TO_WIDTH-1:0] WD_PRE = {{(TO_WIDTH-1){1'b1}}, 1'b0};

  state_e                  state_q, state_d;
  logic [OFF_WIDTH-1:0]    cur_q, cur_d;
  logic [OFF_WIDTH-1:0]    last_q, last_d;
  logic [RC_WIDTH-1:0]     rc_q, rc_d;
  logic [TO_WIDTH-1:0]     wd_q, wd_d;
  logic [STATUS_WIDTH-1:0] status_q, status_d;
  logic                    cap_c;
  logic                    clr_c;
  logic                    abortable_c;

  // Next-state, counters, status and capture/clear strobes
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    rc_d        = rc_q;
    wd_d        = wd_q;
    status_d    = status_q;
    cap_c       = 1'b0;
    clr_c       = 1'b0;
    abortable_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          last_d   = i_off_last;
          status_d = '0;
          clr_c    = 1'b1;
          if (i_off_first > i_off_last) begin
            status_d[STAT_ERR] = 1'b1;
            state_d            = ST_FIN;
          end else begin
            cur_d   = i_off_first;
            rc_d    = '0;
            state_d = ST_ERST;
          end
        end
      end
      ST_ERST: begin
        abortable_c = 1'b1;
        if (rc_q == RC_LAST) begin
          wd_d    = '0;
          state_d = ST_RUN;
        end else begin
          rc_d = rc_q + RC_WIDTH'(1);
        end
      end
      ST_RUN: begin
        abortable_c = 1'b1;
        if (i_eng_done) begin
          state_d = ST_CAPT;
        end else if (wd_q == WD_PRE) begin
          wd_d              = wd_q + TO_WIDTH'(1);
          status_d[STAT_TO] = 1'b1;
          state_d           = ST_NEXT;
        end else begin
          wd_d = wd_q + TO_WIDTH'(1);
        end
      end
      ST_CAPT: begin
        abortable_c = 1'b1;
        cap_c       = 1'b1;
        state_d     = ST_NEXT;
      end
      ST_NEXT: begin
        abortable_c = 1'b1;
        if (cur_q == last_q) begin
          state_d = ST_FIN;
        end else begin
          cur_d   = cur_q + OFF_WIDTH'(1);
          rc_d    = '0;
          state_d = ST_ERST;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides progress but not a capture already under way
    if (abortable_c && i_abort) begin
      status_d[STAT_ABT] = 1'b1;
      cur_d              = cur_q;
      state_d            = ST_FIN;
    end
  end

  // State, counters and registered outputs derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      last_q    <= '0;
      rc_q      <= '0;
      wd_q      <= '0;
      status_q  <= '0;
      o_eng_rst <= 1'b1;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      last_q    <= last_d;
      rc_q      <= rc_d;
      wd_q      <= wd_d;
      status_q  <= status_d;
      o_eng_rst <= !eng_released(state_d);
      o_busy    <= (state_d != ST_IDLE);
      o_done    <= (state_d == ST_FIN);
    end
  end

  // Offset and status are the registers themselves
  always_comb begin
    o_eng_offset = cur_q;
    o_status     = status_q;
  end

  find_sweep_ctrl_best_tracker #(
    .SEQ_WIDTH (SEQ_WIDTH),
    .E_WIDTH   (E_WIDTH),
    .OFF_WIDTH (OFF_WIDTH)
  ) u_best (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_c),
    .cap        (cap_c),
    .seq        (i_eng_seq),
    .e          (i_eng_e),
    .off        (cur_q),
    .best_valid (o_best_valid),
    .best_seq   (o_best_seq),
    .best_e     (o_best_e),
    .best_off   (o_best_off)
  );

endmodule

// File: tb/tb_find_sweep_ctrl.sv
// Self-checking bench for find_sweep_ctrl with a behavioural engine and sweep model.
module tb_find_sweep_ctrl;

  localparam int unsigned SW = 8;
  localparam int unsigned EW = 20;
  localparam int unsigned OW = 7;
  localparam int unsigned TW = 4;
  localparam int DLY = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic          i_abort;
  logic [OW-1:0] i_off_first;
  logic [OW-1:0] i_off_last;
  logic          o_busy;
  logic          o_done;
  logic [2:0]    o_status;
  logic          o_best_valid;
  logic [SW-1:0] o_best_seq;
  logic [EW-1:0] o_best_e;
  logic [OW-1:0] o_best_off;
  logic          o_eng_rst;
  logic [OW-1:0] o_eng_offset;
  logic [SW-1:0] i_eng_seq;
  logic [EW-1:0] i_eng_e;
  logic          i_eng_done;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] e_tab   [0:127];
  logic [SW-1:0] s_tab   [0:127];
  logic          hang    [0:127];
  int            off_cyc [0:127];
  int            eng_cnt = 0;

  always #5 clk = ~clk;

  find_sweep_ctrl #(
    .SEQ_WIDTH (SW), .E_WIDTH (EW), .OFF_WIDTH (OW), .RST_CYCLES (4), .TO_WIDTH (TW)
  ) dut (
    .clk (clk), .rst_n (rst_n), .i_start (i_start), .i_abort (i_abort),
    .i_off_first (i_off_first), .i_off_last (i_off_last),
    .o_busy (o_busy), .o_done (o_done), .o_status (o_status),
    .o_best_valid (o_best_valid), .o_best_seq (o_best_seq), .o_best_e (o_best_e),
    .o_best_off (o_best_off), .o_eng_rst (o_eng_rst), .o_eng_offset (o_eng_offset),
    .i_eng_seq (i_eng_seq), .i_eng_e (i_eng_e), .i_eng_done (i_eng_done)
  );

  // Engine model: finishes DLY cycles after its reset is released unless marked as hanging
  always @(posedge clk) begin
    if (o_eng_rst) eng_cnt <= 0;
    else if (eng_cnt < 10000) eng_cnt <= eng_cnt + 1;
  end
  assign i_eng_done = !hang[o_eng_offset] && (eng_cnt >= DLY - 1);
  assign i_eng_e    = e_tab[o_eng_offset];
  assign i_eng_seq  = s_tab[o_eng_offset];

  // Reference: scan offsets in order, keep strict minimum, skip hung offsets, stop after stop_after
  task automatic model_sweep(input int first, input int last, input int stop_after,
                             output logic v, output logic [EW-1:0] e, output logic [SW-1:0] s,
                             output logic [OW-1:0] off, output logic [2:0] st);
    v = 1'b0; e = '1; s = '0; off = '0; st = 3'b000;
    if (first > last) begin
      st = 3'b100;
      return;
    end
    for (int o = first; o <= last; o++) begin
      if (stop_after >= 0 && o > stop_after) begin
        st[1] = 1'b1;
        break;
      end
      if (hang[o]) st[0] = 1'b1;
      else if (!v || e_tab[o] < e) begin
        v = 1'b1; e = e_tab[o]; s = s_tab[o]; off = OW'(o);
      end
    end
  endtask

  // Drives one sweep and observes it cycle by cycle at the falling edge
  task automatic run_sweep(input int first, input int last, input int abort_off,
                           output int end_t, output int done_t, output int ndone, output bit released);
    int t;
    bit ab_done;
    bit fin;
    for (int i = 0; i < 128; i++) off_cyc[i] = 0;
    end_t = 0; done_t = 0; ndone = 0; released = 1'b0; ab_done = 1'b0; fin = 1'b0; t = 0;
    i_off_first = OW'(first);
    i_off_last  = OW'(last);
    i_start     = 1'b1;
    while (!fin && t < 3000) begin
      @(negedge clk);
      t++;
      i_start = 1'b0;
      i_abort = 1'b0;
      if (o_busy) off_cyc[o_eng_offset]++;
      if (!o_eng_rst) released = 1'b1;
      if (o_done) begin ndone++; done_t = t; end
      if (ndone > 0 && !o_busy) begin
        fin = 1'b1; end_t = t;
      end else if (abort_off >= 0 && !ab_done && !o_eng_rst && int'(o_eng_offset) == abort_off) begin
        i_abort = 1'b1; ab_done = 1'b1;
      end
    end
    n_cmp++; if (!fin) begin n_err++; $display("FAIL sweep_end got still busy after %0d cycles want finished", t); end
  endtask

  task automatic test_reset();
    n_cmp++; if (o_eng_rst !== 1'b1) begin n_err++; $display("FAIL reset_eng_rst got %b want 1", o_eng_rst); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", o_busy); end
    n_cmp++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", o_done); end
    n_cmp++; if (o_status !== 3'b000) begin n_err++; $display("FAIL reset_status got %b want 000", o_status); end
    n_cmp++; if (o_best_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", o_best_valid); end
    n_cmp++; if (o_best_seq !== '0) begin n_err++; $display("FAIL reset_seq got %h want 0", o_best_seq); end
    n_cmp++; if (o_best_e !== 20'hFFFFF) begin n_err++; $display("FAIL reset_e got %h want fffff", o_best_e); end
    n_cmp++; if (o_best_off !== '0) begin n_err++; $display("FAIL reset_off got %0d want 0", o_best_off); end
    n_cmp++; if (o_eng_offset !== '0) begin n_err++; $display("FAIL reset_eng_offset got %0d want 0", o_eng_offset); end
  endtask

  task automatic test_normal_sweep();
    int end_t, done_t, ndone;
    bit rel;
    e_tab[3] = 20'd100; e_tab[4] = 20'd40; e_tab[5] = 20'd70;
    hang[3] = 1'b0; hang[4] = 1'b0; hang[5] = 1'b0;
    run_sweep(3, 5, -1, end_t, done_t, ndone, rel);
    n_cmp++; if (o_best_e !== 20'd40) begin n_err++; $display("FAIL normal_best_e got %0d want 40", o_best_e); end
    n_cmp++; if (o_best_off !== 7'd4) begin n_err++; $display("FAIL normal_best_off got %0d want 4", o_best_off); end
    n_cmp++; if (o_best_seq !== s_tab[4]) begin n_err++; $display("FAIL normal_best_seq got %h want %h", o_best_seq, s_tab[4]); end
    n_cmp++; if (o_best_valid !== 1'b1) begin n_err++; $display("FAIL normal_valid got %b want 1", o_best_valid); end
    n_cmp++; if (o_status !== 3'b000) begin n_err++; $display("FAIL normal_status got %b want 000", o_status); end
    n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL normal_done_pulses got %0d want 1", ndone); end
    n_cmp++; if (end_t < 49 || end_t > 51) begin n_err++; $display("FAIL normal_total_cycles got %0d want 50+-1", end_t); end
    n_cmp++; if (off_cyc[4] != 4 + DLY + 2) begin n_err++; $display("FAIL normal_offset_cycles got %0d want %0d", off_cyc[4], 4 + DLY + 2); end
  endtask

  task automatic test_tie();
    int end_t, done_t, ndone;
    bit rel;
    e_tab[0] = 20'd50; e_tab[1] = 20'd50; hang[0] = 1'b0; hang[1] = 1'b0;
    run_sweep(0, 1, -1, end_t, done_t, ndone, rel);
    n_cmp++; if (o_best_off !== 7'd0) begin n_err++; $display("FAIL tie_best_off got %0d want 0", o_best_off); end
    n_cmp++; if (o_best_e !== 20'd50) begin n_err++; $display("FAIL tie_best_e got %0d want 50", o_best_e); end
  endtask

  task automatic test_range_error();
    int end_t, done_t, ndone;
    bit rel;
    run_sweep(9, 2, -1, end_t, done_t, ndone, rel);
    n_cmp++; if (done_t < 1 || done_t > 2) begin n_err++; $display("FAIL range_done_latency got %0d want 1..2", done_t); end
    n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL range_done_pulses got %0d want 1", ndone); end
    n_cmp++; if (o_status !== 3'b100) begin n_err++; $display("FAIL range_status got %b want 100", o_status); end
    n_cmp++; if (o_best_valid !== 1'b0) begin n_err++; $display("FAIL range_valid got %b want 0", o_best_valid); end
    n_cmp++; if (rel !== 1'b0) begin n_err++; $display("FAIL range_eng_released got %b want 0", rel); end
  endtask

  task automatic test_watchdog();
    int end_t, done_t, ndone;
    bit rel;
    e_tab[6] = 20'd30; e_tab[8] = 20'd30; e_tab[7] = 20'd1;
    hang[6] = 1'b0; hang[7] = 1'b1; hang[8] = 1'b0;
    run_sweep(6, 8, -1, end_t, done_t, ndone, rel);
    hang[7] = 1'b0;
    n_cmp++; if (o_status !== 3'b001) begin n_err++; $display("FAIL wd_status got %b want 001", o_status); end
    n_cmp++; if (o_best_off !== 7'd6) begin n_err++; $display("FAIL wd_best_off got %0d want 6", o_best_off); end
    n_cmp++; if (o_best_e !== 20'd30) begin n_err++; $display("FAIL wd_best_e got %0d want 30", o_best_e); end
    // Hung offset: reset 4 + watchdog 15 + NEXT 1, no capture cycle
    n_cmp++; if (off_cyc[7] != 20) begin n_err++; $display("FAIL wd_offset_cycles got %0d want 20", off_cyc[7]); end
  endtask

  task automatic test_abort();
    int end_t, done_t, ndone;
    bit rel;
    logic v; logic [EW-1:0] e; logic [SW-1:0] s; logic [OW-1:0] off; logic [2:0] st;
    e_tab[10] = 20'd500; e_tab[11] = 20'd5; e_tab[12] = 20'd1;
    hang[10] = 1'b0; hang[11] = 1'b0; hang[12] = 1'b0;
    model_sweep(10, 12, 10, v, e, s, off, st);
    run_sweep(10, 12, 11, end_t, done_t, ndone, rel);
    n_cmp++; if (o_status !== st) begin n_err++; $display("FAIL abort_status got %b want %b", o_status, st); end
    n_cmp++; if (o_best_off !== off) begin n_err++; $display("FAIL abort_best_off got %0d want %0d", o_best_off, off); end
    n_cmp++; if (o_best_e !== e) begin n_err++; $display("FAIL abort_best_e got %0d want %0d", o_best_e, e); end
    n_cmp++; if (o_eng_rst !== 1'b1) begin n_err++; $display("FAIL abort_eng_rst got %b want 1", o_eng_rst); end
    n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL abort_done_pulses got %0d want 1", ndone); end
  endtask

  task automatic test_async_reset();
    int end_t, done_t, ndone, w;
    bit rel;
    logic v; logic [EW-1:0] e; logic [SW-1:0] s; logic [OW-1:0] off; logic [2:0] st;
    for (int i = 0; i < 4; i++) begin e_tab[i] = EW'($urandom_range(0, 999)); hang[i] = 1'b0; end
    i_off_first = 7'd0; i_off_last = 7'd3; i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
    w = 0;
    while (o_eng_rst && w < 100) begin @(negedge clk); w++; end
    n_cmp++; if (o_eng_rst !== 1'b0) begin n_err++; $display("FAIL arst_reach_run got eng_rst %b want 0", o_eng_rst); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (o_eng_rst !== 1'b1) begin n_err++; $display("FAIL arst_eng_rst got %b want 1", o_eng_rst); end
    n_cmp++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL arst_busy got %b want 0", o_busy); end
    n_cmp++; if (o_best_e !== 20'hFFFFF) begin n_err++; $display("FAIL arst_best_e got %h want fffff", o_best_e); end
    n_cmp++; if (o_best_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %b want 0", o_best_valid); end
    n_cmp++; if (o_eng_offset !== '0) begin n_err++; $display("FAIL arst_eng_offset got %0d want 0", o_eng_offset); end
    n_cmp++; if (o_status !== 3'b000) begin n_err++; $display("FAIL arst_status got %b want 000", o_status); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    model_sweep(0, 3, -1, v, e, s, off, st);
    run_sweep(0, 3, -1, end_t, done_t, ndone, rel);
    n_cmp++; if (o_best_e !== e) begin n_err++; $display("FAIL arst_resweep_e got %0d want %0d", o_best_e, e); end
    n_cmp++; if (o_best_off !== off) begin n_err++; $display("FAIL arst_resweep_off got %0d want %0d", o_best_off, off); end
    n_cmp++; if (o_status !== st) begin n_err++; $display("FAIL arst_resweep_status got %b want %b", o_status, st); end
  endtask

  task automatic test_random();
    int end_t, done_t, ndone, first, last;
    bit rel;
    logic v; logic [EW-1:0] e; logic [SW-1:0] s; logic [OW-1:0] off; logic [2:0] st;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 32; i++) begin
        e_tab[i] = EW'($urandom_range(0, 7) * 10);
        s_tab[i] = SW'($urandom);
        hang[i]  = ($urandom_range(0, 4) == 0);
      end
      first = $urandom_range(0, 20);
      last  = first + $urandom_range(0, 4);
      if ($urandom_range(0, 5) == 0 && first > 0) last = $urandom_range(0, first - 1);
      model_sweep(first, last, -1, v, e, s, off, st);
      run_sweep(first, last, -1, end_t, done_t, ndone, rel);
      n_cmp++; if (o_best_valid !== v) begin n_err++; $display("FAIL rnd%0d_valid got %b want %b", n, o_best_valid, v); end
      n_cmp++; if (o_best_e !== e) begin n_err++; $display("FAIL rnd%0d_best_e got %0d want %0d", n, o_best_e, e); end
      n_cmp++; if (o_best_off !== off) begin n_err++; $display("FAIL rnd%0d_best_off got %0d want %0d", n, o_best_off, off); end
      n_cmp++; if (o_best_seq !== s) begin n_err++; $display("FAIL rnd%0d_best_seq got %h want %h", n, o_best_seq, s); end
      n_cmp++; if (o_status !== st) begin n_err++; $display("FAIL rnd%0d_status got %b want %b", n, o_status, st); end
      n_cmp++; if (ndone != 1) begin n_err++; $display("FAIL rnd%0d_done_pulses got %0d want 1", n, ndone); end
    end
    for (int i = 0; i < 128; i++) hang[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) begin
      e_tab[i] = EW'($urandom_range(0, 1000));
      s_tab[i] = SW'($urandom);
      hang[i]  = 1'b0;
    end
    rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_off_first = '0; i_off_last = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_normal_sweep();
    test_tie();
    test_range_error();
    test_watchdog();
    test_abort();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
